// File: rtl/shift_unit_seq_pkg.sv
// Shared opcodes and FSM state encoding for the sequential shift/rotate unit.
package shift_unit_seq_pkg;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_unit_seq_shift_stage.sv
// One conditional shift/rotate by 2**idx_i; passes data through when en_i is low.
module shift_stage
  import shift_unit_seq_pkg::*;
#(
  parameter int unsigned N    = 16,
  parameter int unsigned C    = 4,
  parameter int unsigned IdxW = (C > 1) ? $clog2(C) : 1
) (
  input  logic [N-1:0]    data_i,
  input  logic [1:0]      op_i,
  input  logic [IdxW-1:0] idx_i,
  input  logic            en_i,
  output logic [N-1:0]    data_o
);

  int unsigned k;
  logic [N-1:0] shifted;

  always_comb begin
    k       = 32'd1 << idx_i;
    shifted = data_i;
    unique case (op_i)
      OP_ROL:  shifted = (data_i << k) | (data_i >> (N - k));
      OP_SLL:  shifted = data_i << k;
      OP_ROR:  shifted = (data_i >> k) | (data_i << (N - k));
      OP_SRA:  shifted = $signed(data_i) >>> k;
      default: shifted = data_i;
    endcase
    data_o = en_i ? shifted : data_i;
  end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shift/rotate unit: resolves one count bit per cycle, MSB first,
// with valid/ready handshakes on both sides.
module shift_unit_seq
  import shift_unit_seq_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned C = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [C-1:0] in_cnt,
  input  logic [1:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy
);

  localparam int unsigned IdxW = (C > 1) ? $clog2(C) : 1;

  state_e          state_q, state_d;
  logic [N-1:0]    acc_q, acc_d;
  logic [C-1:0]    cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [N-1:0]    stage_out;

  shift_stage #(
    .N    (N),
    .C    (C),
    .IdxW (IdxW)
  ) u_stage (
    .data_i (acc_q),
    .op_i   (op_q),
    .idx_i  (idx_q),
    .en_i   (cnt_q[idx_q]),
    .data_o (stage_out)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d   = in_data;
          cnt_d   = in_cnt;
          op_d    = in_op;
          idx_d   = IdxW'(C - 1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_d = stage_out;
        if (idx_q == '0) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
    end
  end

  assign out_data = acc_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: doc/shift_unit_seq.md
Name: shift_unit_seq

Overview:
- Multi-cycle shift/rotate execution unit for the 16-bit datapath.
- Sits between decode/operand-read (upstream) and writeback (downstream).
- Resolves one count bit per cycle, MSB first: shift by 8, then 4, then 2, then 1.
- Supports rotate-left, logical shift-left, rotate-right and arithmetic shift-right.
- Valid/ready handshake on both sides, so the pipeline can stall it.

Parameters:
- N, 16, data width; must equal 2**C.
- C, 4, shift-count width; also the number of shift cycles per operation.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents an operation.
- in_ready  out  1  unit can accept an operation.
- in_data  in  N  operand.
- in_cnt  in  C  shift amount, 0..N-1.
- in_op  in  2  operation: 00 ROL, 01 SLL, 10 ROR, 11 SRA.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_data  out  N  result.
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- Clocking: all state changes on the rising edge of clk. rst is synchronous and active-high, and overrides every other input.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, internal count/op/index registers=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_data into the accumulator (drives out_data), latch in_cnt and in_op, set idx=C-1, go to SHIFT.
  - in_valid low: stay IDLE, registers hold.
- SHIFT:
  - in_ready=0.
  - Each edge: if cnt[idx]=1, replace the accumulator with its shift by 2**idx using the latched op; else hold it.
  - If idx=0, go to DONE; else decrement idx.
- DONE:
  - out_valid=1, in_ready=0.
  - out_data holds stable until out_ready=1; on that edge go to IDLE and drop out_valid.
- Latency: acceptance at edge E0 gives out_valid=1 after edge E0+C (4 cycles at default), independent of count value.
- Throughput: one operation per C+2 cycles with no backpressure.
- No new acceptance is possible in the DONE cycle, because in_ready is low outside IDLE.
- Per-stage arithmetic, shift amount k=2**idx, width N, no width growth:
  - ROL: {a[N-1-k:0], a[N-1:N-k]}
  - SLL: {a[N-1-k:0], k zeros}
  - ROR: {a[k-1:0], a[N-1:k]}
  - SRA: {k copies of a[N-1], a[N-1:k]}
- Composition: the staged result equals a single shift of the original operand by cnt.
- Count 0: all stages hold, out_data=in_data, same latency.
- Count N-1 (15):
  - SRA gives all sign bits.
  - SLL gives {in_data[0], 15 zeros}.
  - Rotates wrap correctly.
- Input stability: in_data, in_cnt and in_op are ignored outside the acceptance edge; changes while busy have no effect.
- Reset mid-operation (SHIFT or DONE): the operation is discarded, all registers return to reset values, and no out_valid pulse occurs.
- out_ready asserted while not in DONE is ignored.
- in_valid asserted while busy is not lost by the unit; upstream holds it until in_ready.

Decomposition:
- Shared package: opcode constants OP_ROL=2'b00, OP_SLL=2'b01, OP_ROR=2'b10, OP_SRA=2'b11; state encodings ST_IDLE, ST_SHIFT, ST_DONE.
- Sub-module shift_stage: combinational single conditional shift.
  - Inputs: data, op, stage index, enable bit.
  - Output: shifted data.
  - Instantiated once, with idx selecting the amount.
- The FSM, accumulator and handshake logic stay in shift_unit_seq.

Test Plan:
- SRA, in_data=0x8000, cnt=4, out_ready=1 -> out_data=0xF800 with out_valid high after edge E0+4; in_ready low during edges E0+1..E0+4.
- SLL 0x0001 cnt=15 -> 0x8000. ROL 0x8001 cnt=1 -> 0x0003. ROR 0x0001 cnt=4 -> 0x1000. SRA 0x7FF0 cnt=15 -> 0x0000.
- Count 0, each op, in_data=0xA5C3 -> out_data=0xA5C3 after the same 4-cycle latency.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable; in_data changed meanwhile has no effect; out_ready=1 -> IDLE next edge, in_ready=1.
- rst pulsed during SHIFT (idx=2) -> next edge state IDLE, out_data=0, out_valid never asserted; a following SRA 0xFFFF cnt=8 returns 0xFFFF.
- Back-to-back ops with in_valid held high -> second accept only in IDLE, exactly C+2 cycles after the first.
